sram_mem_stage: RTL and testbench

SRAM_MEM_STAGE -- requirements
Module: sram_mem_stage

---
 rtl/sram_mem_stage.sv | 179 +++++++++++++++++
 tb/tb_sram_mem_stage.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_mem_stage.sv
// -----------------------------------------------------------------------------
// sram_mem_stage
//
// Memory stage of a pipelined core in front of a 16-bit asynchronous SRAM.
// Each 32-bit load or store is split into two half-word accesses. The low
// half-word goes first (LO phase) and the high half-word follows (HI phase).
// While an access is in flight, `ready` is held low so the pipeline freezes.
//
// Optional feature: define SRAM_WAIT_STATE_EN to stretch LO and HI to two
// cycles each for slower SRAM parts. Reads then sample on the second cycle.
//
// Parameters
//   BASE_ADDR   byte address that maps to SRAM word 0
//
// Ports
//   clk         clock; all state updates on the rising edge
//   rst         asynchronous, active-low reset
//   mem_R_en    load request from execute
//   mem_W_en    store request from execute (takes priority over mem_R_en)
//   alu_result  byte address from execute
//   st_val      store data
//   read_data   last completed load word
//   ready       low = freeze pipeline
//   SRAM_DQ     bidirectional 16-bit SRAM data bus
//   SRAM_ADDR   SRAM half-word address
//   SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N
//               active-low SRAM controls
// -----------------------------------------------------------------------------
module sram_mem_stage #(
    parameter logic [31:0] BASE_ADDR = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_R_en,
    input  logic        mem_W_en,
    input  logic [31:0] alu_result,
    input  logic [31:0] st_val,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic        is_write_reg, is_write_next;
    logic [15:0] low_half_reg, low_half_next;
    logic [31:0] read_data_reg, read_data_next;

    logic        request;
    logic        phase_last;
    logic        active;
    logic        dq_drive;
    logic [15:0] dq_out;
    logic [31:0] offset;
    logic        unused_offset_bits;

    assign request = mem_R_en | mem_W_en;

    // Word offset into the SRAM. The subtraction wraps, so addresses below
    // BASE_ADDR land at the top of the SRAM.
    assign offset             = alu_result - BASE_ADDR;
    assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

`ifdef SRAM_WAIT_STATE_EN
    // Each half-word phase lasts two cycles. wait_reg is 1 in the second cycle.
    logic wait_reg, wait_next;
    assign phase_last = wait_reg;
`else
    assign phase_last = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        is_write_next  = is_write_reg;
        low_half_next  = low_half_reg;
        read_data_next = read_data_reg;
`ifdef SRAM_WAIT_STATE_EN
        wait_next      = 1'b0;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (request) begin
                    state_next = ST_LO;
                    // Lock in the operation type now. Later input changes
                    // must not turn a read into a write mid-access.
                    is_write_next = mem_W_en;
                end
            end
            ST_LO: begin
`ifdef SRAM_WAIT_STATE_EN
                wait_next = ~wait_reg;
`endif
                if (phase_last) begin
                    state_next = ST_HI;
                    // Keep the low half aside so read_data changes only
                    // once, when the whole word is in.
                    if (!is_write_reg) begin
                        low_half_next = SRAM_DQ;
                    end
                end
            end
            ST_HI: begin
`ifdef SRAM_WAIT_STATE_EN
                wait_next = ~wait_reg;
`endif
                if (phase_last) begin
                    state_next = ST_DONE;
                    if (!is_write_reg) begin
                        read_data_next = {SRAM_DQ, low_half_reg};
                    end
                end
            end
            ST_DONE: begin
                // The request is still asserted here. It is ignored, and a
                // new access can only start from IDLE.
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            is_write_reg  <= 1'b0;
            low_half_reg  <= 16'd0;
            read_data_reg <= 32'd0;
`ifdef SRAM_WAIT_STATE_EN
            wait_reg      <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            is_write_reg  <= is_write_next;
            low_half_reg  <= low_half_next;
            read_data_reg <= read_data_next;
`ifdef SRAM_WAIT_STATE_EN
            wait_reg      <= wait_next;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs. These are decoded from state, so an asynchronous reset
    // releases the SRAM bus in the same cycle.
    // ------------------------------------------------------------------
    assign active   = (state_reg == ST_LO) || (state_reg == ST_HI);
    assign dq_drive = active && is_write_reg;
    assign dq_out   = (state_reg == ST_HI) ? st_val[31:16] : st_val[15:0];

    assign SRAM_DQ   = dq_drive ? dq_out : 16'bz;
    assign SRAM_ADDR = {offset[18:2], (state_reg == ST_HI)};
    assign SRAM_CE_N = ~active;
    assign SRAM_UB_N = ~active;
    assign SRAM_LB_N = ~active;
    assign SRAM_WE_N = ~dq_drive;
    assign SRAM_OE_N = ~(active && !is_write_reg);

    assign ready     = ~(request && (state_reg != ST_DONE));
    assign read_data = read_data_reg;

endmodule

// File: tb/tb_sram_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_sram_mem_stage
//
// Scoreboard bench for sram_mem_stage, driven by a behavioural SRAM model.
//
// The stimulus process issues directed accesses. For each access it pushes
// two kinds of expectation:
//   - the half-word writes it expects to see on the SRAM bus;
//   - the completion record: read_data value and number of ready-low cycles.
//
// A separate monitor samples on the falling edge and compares every SRAM
// write strobe and every rising edge of ready against those queues.
// -----------------------------------------------------------------------------
module tb_sram_mem_stage;

`ifdef SRAM_WAIT_STATE_EN
    localparam int HALF_CYC = 2;
    localparam int LOW_CYC  = 5;
`else
    localparam int HALF_CYC = 1;
    localparam int LOW_CYC  = 3;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_R_en;
    logic        mem_W_en;
    logic [31:0] alu_result;
    logic [31:0] st_val;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

    always #5 clk = ~clk;

    sram_mem_stage #(.BASE_ADDR(32'd1024)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_R_en   (mem_R_en),
        .mem_W_en   (mem_W_en),
        .alu_result (alu_result),
        .st_val     (st_val),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_DQ    (sram_dq),
        .SRAM_ADDR  (sram_addr),
        .SRAM_WE_N  (sram_we_n),
        .SRAM_OE_N  (sram_oe_n),
        .SRAM_CE_N  (sram_ce_n),
        .SRAM_UB_N  (sram_ub_n),
        .SRAM_LB_N  (sram_lb_n)
    );

    // SRAM model: 256 half-words, indexed by the low address bits.
    logic [15:0] mem [0:255];
    logic        tb_drive;
    assign tb_drive = !sram_oe_n && !sram_ce_n && sram_we_n;
    assign sram_dq  = tb_drive ? mem[sram_addr[7:0]] : 16'bz;

    typedef struct {
        logic [17:0] addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] rd;
        int          low;   // -1: do not check the ready-low length
        string       name;
    } cmp_t;

    wr_t  wr_q[$];
    cmp_t cmp_q[$];

    int checks = 0;
    int passes = 0;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endfunction

    task automatic expect_write(input logic [17:0] ha, input logic [31:0] data);
        for (int i = 0; i < HALF_CYC; i++) wr_q.push_back('{ha, data[15:0]});
        for (int i = 0; i < HALF_CYC; i++) wr_q.push_back('{ha | 18'd1, data[31:16]});
    endtask

    task automatic expect_done(input logic [31:0] rd, input int low, input string nm);
        cmp_q.push_back('{rd, low, nm});
    endtask

    // Called at posedge+1. Returns in DONE at posedge+1. If hold is 0, the
    // request is dropped and the task returns one cycle later, in IDLE.
    task automatic run(input logic w, input logic r, input logic [31:0] addr,
                       input logic [31:0] data, input logic hold);
        int n;
        mem_W_en   = w;
        mem_R_en   = r;
        alu_result = addr;
        st_val     = data;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ready && n < 20);
        if (!ready) begin
            checks++;
            $display("FAIL timeout waiting for ready: got 0 expected 1");
        end
        if (!hold) begin
            mem_W_en = 1'b0;
            mem_R_en = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    initial begin
        automatic int   low_cnt    = 0;
        automatic logic prev_ready = 1'b1;
        automatic wr_t  e;
        automatic cmp_t c;
        forever begin
            @(negedge clk);
            if (!sram_ce_n && !sram_we_n) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_write: got addr %h data %h expected none",
                             sram_addr, sram_dq);
                end else begin
                    e = wr_q.pop_front();
                    check("wr_addr", {14'd0, sram_addr}, {14'd0, e.addr});
                    check("wr_data", {16'd0, sram_dq}, {16'd0, e.data});
                    check("wr_oe_n", {31'd0, sram_oe_n}, 32'd1);
                end
                mem[sram_addr[7:0]] = sram_dq;
            end
            if (!sram_oe_n) check("rd_we_n", {31'd0, sram_we_n}, 32'd1);
            if (ready && !prev_ready) begin
                if (cmp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_ready_pulse: got pulse expected none");
                end else begin
                    c = cmp_q.pop_front();
                    check({c.name, "_read_data"}, read_data, c.rd);
                    if (c.low >= 0) check({c.name, "_ready_low"}, low_cnt, c.low);
                    $display("txn %s: read_data=%h ready_low_cycles=%0d", c.name, read_data, low_cnt);
                end
            end
            if (ready) low_cnt = 0;
            else       low_cnt++;
            prev_ready = ready;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        automatic int n;
        for (int i = 0; i < 256; i++) mem[i] = 16'hA500 | 16'(i);
        rst        = 1'b0;
        mem_R_en   = 1'b0;
        mem_W_en   = 1'b0;
        alu_result = 32'd0;
        st_val     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", {31'd0, ready}, 32'd1);
        check("reset_read_data", read_data, 32'd0);
        check("reset_we_n", {31'd0, sram_we_n}, 32'd1);
        check("reset_oe_n", {31'd0, sram_oe_n}, 32'd1);
        check("reset_ctl_n", {29'd0, sram_ce_n, sram_ub_n, sram_lb_n}, 32'd7);
        @(posedge clk); #1;
        rst = 1'b1;

        // Store DEADBEEF at byte 1028 -> half-words 2 and 3.
        expect_write(18'd2, 32'hDEADBEEF);
        expect_done(32'd0, LOW_CYC, "write_1028");
        run(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 1'b0);

        // Load it back.
        expect_done(32'hDEADBEEF, LOW_CYC, "read_1028");
        run(1'b0, 1'b1, 32'd1028, 32'd0, 1'b0);

        // Both enables set -> write; read_data must not change.
        expect_write(18'd4, 32'h12345678);
        expect_done(32'hDEADBEEF, LOW_CYC, "both_1032");
        run(1'b1, 1'b1, 32'd1032, 32'h12345678, 1'b0);

        // Address below BASE_ADDR wraps to the top of SRAM.
        expect_write(18'h3FFFE, 32'hCAFEF00D);
        expect_done(32'hDEADBEEF, LOW_CYC, "write_wrap_1020");
        run(1'b1, 1'b0, 32'd1020, 32'hCAFEF00D, 1'b0);

        // Back-to-back reads with the request held through DONE.
        expect_done(32'hCAFEF00D, LOW_CYC, "b2b_read_1020");
        expect_done(32'h12345678, LOW_CYC, "b2b_read_1032");
        run(1'b0, 1'b1, 32'd1020, 32'd0, 1'b1);
        alu_result = 32'd1032;
        @(posedge clk); #1;
        check("b2b_idle_ready", {31'd0, ready}, 32'd0);
        check("b2b_idle_ce_n", {31'd0, sram_ce_n}, 32'd1);
        run(1'b0, 1'b1, 32'd1032, 32'd0, 1'b0);

        // Reset during the HI phase of a write. Only the LO half reaches SRAM.
        expect_write(18'd8, 32'h5555AAAA);
        void'(wr_q.pop_back());
        if (HALF_CYC == 2) void'(wr_q.pop_back());
        expect_done(32'd0, -1, "reset_mid_write");
        mem_W_en   = 1'b1;
        alu_result = 32'd1040;
        st_val     = 32'h5555AAAA;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(!sram_ce_n && sram_addr[0]) && n < 20);
        check("reached_hi_phase", {31'd0, sram_addr[0]}, 32'd1);
        rst      = 1'b0;
        mem_W_en = 1'b0;
        #1;
        check("midrst_we_n", {31'd0, sram_we_n}, 32'd1);
        check("midrst_ce_n", {31'd0, sram_ce_n}, 32'd1);
        check("midrst_ready", {31'd0, ready}, 32'd1);
        check("midrst_read_data", read_data, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Accepted on the first edge after reset. The half-word written
        // before reset stays, and the upper half is the old content.
        expect_done(32'hA509AAAA, LOW_CYC, "read_after_reset_1040");
        run(1'b0, 1'b1, 32'd1040, 32'd0, 1'b0);

        n = 0;
        while ((wr_q.size() != 0 || cmp_q.size() != 0) && n < 10) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        check("wr_q_drained", wr_q.size(), 32'd0);
        check("cmp_q_drained", cmp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
